// File: rtl/itu_656_encoder.sv
// ITU-R BT.656 525-line byte-stream encoder; pulls 4:2:2 words via oRequest.
// Define ITU656_ENC_CLIP_EN to clamp active bytes to 01..FE.
module itu_656_encoder #(
    parameter int H_BLANK   = 268,
    parameter int H_ACTIVE  = 1440,
    parameter int V_TOTAL   = 525,
    parameter int F1_START  = 266,
    parameter int F0_START  = 4,
    parameter int VB0_END   = 19,
    parameter int VB1_START = 264,
    parameter int VB1_END   = 282
) (
    input  logic        iCLK_27,
    input  logic        iRST_N,
    input  logic [15:0] iYCbCr,
    input  logic        iDVAL,
    output logic        oRequest,
    output logic [7:0]  oTD_DATA,
    output logic [9:0]  oTV_X,
    output logic [9:0]  oTV_Y,
    output logic        oField,
    output logic        oVBLANK,
    output logic        oUNDERFLOW
);

    localparam logic [10:0] SAV_H  = 11'(4 + H_BLANK);
    localparam logic [10:0] ACT_H  = 11'(8 + H_BLANK);
    localparam logic [10:0] H_LAST = 11'(8 + H_BLANK + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL);
    localparam logic [9:0]  F1_L   = 10'(F1_START);
    localparam logic [9:0]  F0_L   = 10'(F0_START);
    localparam logic [9:0]  VB0_L  = 10'(VB0_END);
    localparam logic [9:0]  VB1S_L = 10'(VB1_START);
    localparam logic [9:0]  VB1E_L = 10'(VB1_END);

    logic [10:0] h;
    logic [9:0]  v;
    logic [7:0]  y_hold;
    logic [7:0]  byte_nxt;
    logic [7:0]  w_c;
    logic [7:0]  w_y;
    logic        line_f;
    logic        line_v;
    logic        in_act;
    logic        req_nxt;

    function automatic logic [7:0] xy(input logic f, input logic vb, input logic hb);
        return {1'b1, f, vb, hb, vb ^ hb, f ^ hb, f ^ vb, f ^ vb ^ hb};
    endfunction

    // Keeps video from ever producing the FF/00 timing-code preamble.
    function automatic logic [7:0] clip8(input logic [7:0] b);
`ifdef ITU656_ENC_CLIP_EN
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
`else
        return b;
`endif
    endfunction

    always_comb begin
        line_f   = (v >= F1_L) || (v < F0_L);
        line_v   = (v <= VB0_L) || ((v >= VB1S_L) && (v <= VB1E_L));
        in_act   = h >= ACT_H;
        w_c      = iDVAL ? iYCbCr[7:0]  : 8'h80;
        w_y      = iDVAL ? iYCbCr[15:8] : 8'h10;
        byte_nxt = h[0] ? 8'h10 : 8'h80;
        unique case (1'b1)
            (h == 11'd0) || (h == SAV_H):
                byte_nxt = 8'hFF;
            (h == 11'd1) || (h == 11'd2) ||
            (h == SAV_H + 11'd1) || (h == SAV_H + 11'd2):
                byte_nxt = 8'h00;
            (h == 11'd3):
                byte_nxt = xy(line_f, line_v, 1'b1);
            (h == SAV_H + 11'd3):
                byte_nxt = xy(line_f, line_v, 1'b0);
            in_act && !line_v && !h[0]:
                byte_nxt = clip8(w_c);
            in_act && !line_v && h[0]:
                byte_nxt = clip8(y_hold);
            default: ;
        endcase
        // One pull at SAV XY, then on every Y byte but the line's last.
        req_nxt = !line_v &&
                  ((h == SAV_H + 11'd3) || (in_act && h[0] && (h != H_LAST)));
    end

    always_ff @(posedge iCLK_27 or negedge iRST_N) begin
        if (!iRST_N) begin
            h          <= '0;
            v          <= 10'd1;
            y_hold     <= 8'h10;
            oTD_DATA   <= 8'h10;
            oRequest   <= 1'b0;
            oTV_X      <= '0;
            oTV_Y      <= 10'd1;
            oField     <= 1'b1;
            oVBLANK    <= 1'b1;
            oUNDERFLOW <= 1'b0;
        end else begin
            oTD_DATA <= byte_nxt;
            oRequest <= req_nxt;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd1 : v + 10'd1;
            end else begin
                h <= h + 11'd1;
            end
            if (oRequest) begin
                y_hold <= w_y;
                oTV_X  <= 10'((h - ACT_H) >> 1);
                if (!iDVAL) oUNDERFLOW <= 1'b1;
            end else if (h == 11'd0) begin
                oTV_X <= '0;
            end
            if (h == 11'd0) begin
                oTV_Y   <= v;
                oField  <= line_f;
                oVBLANK <= line_v;
            end
        end
    end

endmodule

// File: tb/tb_itu_656_encoder.sv
// Randomized bench for itu_656_encoder against a position-based stream model.
// Uses a shortened line so a full 525-line frame fits the run.
module tb_itu_656_encoder;

    localparam int HB   = 20;
    localparam int HA   = 48;
    localparam int LINE = HB + HA + 8;
    localparam int SAVP = 4 + HB;
    localparam int ACTP = SAVP + 4;
    localparam int VT   = 525;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ycbcr = '0;
    logic        dval = 1'b0;
    logic        req;
    logic [7:0]  td;
    logic [9:0]  tv_x;
    logic [9:0]  tv_y;
    logic        field;
    logic        vblank;
    logic        uflow;

    always #5 clk = ~clk;

    itu_656_encoder #(.H_BLANK(HB), .H_ACTIVE(HA)) dut (
        .iCLK_27   (clk),
        .iRST_N    (rst_n),
        .iYCbCr    (ycbcr),
        .iDVAL     (dval),
        .oRequest  (req),
        .oTD_DATA  (td),
        .oTV_X     (tv_x),
        .oTV_Y     (tv_y),
        .oField    (field),
        .oVBLANK   (vblank),
        .oUNDERFLOW(uflow)
    );

    int         checks = 0;
    int         fails = 0;
    int         n = 0;
    bit         exp_uf = 0;
    bit         rand_dval = 0;
    int         drop_line = -1;
    int         drop_word = -1;
    logic [7:0] q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (byte %0d)", tag, got, exp, n);
        end
    endtask

    function automatic bit f_bit(int l);
        return (l >= 266) || (l < 4);
    endfunction

    function automatic bit v_bit(int l);
        return (l <= 19) || (l >= 264 && l <= 282);
    endfunction

    function automatic logic [7:0] code(bit f, bit vb, bit hb);
        int s;
        s = 128 + 64 * f + 32 * vb + 16 * hb + 8 * (vb ^ hb) +
            4 * (f ^ hb) + 2 * (f ^ vb) + (f ^ vb ^ hb);
        return 8'(s);
    endfunction

    function automatic logic [7:0] clipm(logic [7:0] b);
`ifdef ITU656_ENC_CLIP_EN
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
`endif
        return b;
    endfunction

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(7);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    // Check the byte shown now (stream index n), then present the next word.
    task automatic step();
        int pos, line, k;
        bit fb, vb, xreq, dv;
        logic [7:0] eb, c, y;
        pos  = n % LINE;
        line = (n / LINE) % VT + 1;
        fb   = f_bit(line);
        vb   = v_bit(line);
        xreq = !vb && (pos == SAVP + 3 ||
                       (pos >= ACTP && pos % 2 == 1 && pos != LINE - 1));
        if (pos < 4)
            eb = (pos == 0) ? 8'hFF : (pos == 3) ? code(fb, vb, 1) : 8'h00;
        else if (pos >= SAVP && pos < ACTP)
            eb = (pos == SAVP) ? 8'hFF : (pos == SAVP + 3) ? code(fb, vb, 0) : 8'h00;
        else if (pos >= ACTP && !vb)
            eb = (q.size() > 0) ? q.pop_front() : 8'hxx;
        else
            eb = (pos % 2 == 1) ? 8'h10 : 8'h80;
        check("data", 32'(td), 32'(eb));
        check("request", 32'(req), 32'(xreq));
        check("tv_y", 32'(tv_y), 32'(line));
        check("field", 32'(field), 32'(fb));
        check("vblank", 32'(vblank), 32'(vb));
        check("underflow", 32'(uflow), 32'(exp_uf));
        check("tv_x", 32'(tv_x), (pos >= ACTP && !vb) ? 32'((pos - ACTP) / 2) : 32'd0);
        c  = pick();
        y  = pick();
        dv = rand_dval ? ($urandom_range(15) != 0) : 1'b1;
        if (xreq) begin
            k = (pos == SAVP + 3) ? 0 : (pos - ACTP + 1) / 2;
            if (line == drop_line && k == drop_word) dv = 0;
            if (dv) begin
                q.push_back(clipm(c));
                q.push_back(clipm(y));
            end else begin
                q.push_back(8'h80);
                q.push_back(8'h10);
                exp_uf = 1;
            end
        end
        ycbcr = {y, c};
        dval  = dv;
        n++;
        @(negedge clk);
    endtask

    task automatic restart();
        n      = 0;
        exp_uf = 0;
        q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", 32'(td), 32'h10);
        check("rst_request", 32'(req), 32'd0);
        check("rst_tv_x", 32'(tv_x), 32'd0);
        check("rst_tv_y", 32'(tv_y), 32'd1);
        check("rst_field", 32'(field), 32'd1);
        check("rst_vblank", 32'(vblank), 32'd1);
        check("rst_underflow", 32'(uflow), 32'd0);

        drop_line = 30;
        drop_word = 5;
        rand_dval = 0;
        restart();
        rst_n = 1'b1;
        @(negedge clk);
        repeat (528 * LINE + 30) step();

        // Mid-line reset on line 4 of the second frame.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(td), 32'h10);
        check("midrst_request", 32'(req), 32'd0);
        check("midrst_underflow", 32'(uflow), 32'd0);
        check("midrst_tv_y", 32'(tv_y), 32'd1);
        @(negedge clk);
        drop_line = -1;
        rand_dval = 1;
        restart();
        rst_n = 1'b1;
        @(negedge clk);
        repeat (25 * LINE) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
